// File: rtl/fphub_pkg.sv
// +----------------------------------------------------------------------------+
// | fphub_pkg                                                                  |
// | Shared types, default widths and result classification for FPHUB stages.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package fphub_pkg;

  localparam int FPHUB_M_DEFAULT = 23;
  localparam int FPHUB_E_DEFAULT = 8;

  typedef struct packed {
    logic cancel;
    logic sat;
    logic zero;
  } fphub_res_flags_t;

  // Sign is deliberately ignored: both signed zeros classify as zero.
  function automatic fphub_res_flags_t fphub_classify(
    input logic exp_all_zero,
    input logic exp_all_ones,
    input logic frac_all_zero
  );
    fphub_res_flags_t f;
    f.cancel = 1'b0;
    f.sat    = exp_all_ones;
    f.zero   = exp_all_zero & frac_all_zero;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fphub_skid_buffer.sv
// +----------------------------------------------------------------------------+
// | fphub_skid_buffer                                                          |
// | Generic 2-entry valid/ready buffer: output register plus skid register.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module fphub_skid_buffer #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_or_valid;
  logic [W-1:0] r_or_data;
  logic         r_sr_valid;
  logic [W-1:0] r_sr_data;
  logic         r_in_ready;

  logic w_accept;
  logic w_deliver;

  assign w_accept  = in_valid & r_in_ready;
  assign w_deliver = r_or_valid & out_ready;

  // in_ready is its own flop so it never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_sr_valid <= 1'b0;
      r_sr_data  <= '0;
      r_in_ready <= 1'b1;
    end else if (!r_or_valid) begin
      if (w_accept) begin
        r_or_data  <= in_data;
        r_or_valid <= 1'b1;
      end
    end else if (!r_sr_valid) begin
      if (w_accept && w_deliver) begin
        r_or_data <= in_data;
      end else if (w_accept) begin
        r_sr_data  <= in_data;
        r_sr_valid <= 1'b1;
        r_in_ready <= 1'b0;
      end else if (w_deliver) begin
        r_or_valid <= 1'b0;
      end
    end else if (w_deliver) begin
      r_or_data  <= r_sr_data;
      r_sr_valid <= 1'b0;
      r_in_ready <= 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_or_valid;
  assign out_data  = r_or_data;

endmodule

`default_nettype wire

// File: rtl/fphub_adder_result_stage.sv
// +----------------------------------------------------------------------------+
// | fphub_adder_result_stage                                                   |
// | Registered, back-pressurable output stage for the FPHUB adder with result |
// | classification and sticky status. FPHUB_RESULT_STATS_EN adds res_count.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module fphub_adder_result_stage
  import fphub_pkg::*;
#(
  parameter int M         = FPHUB_M_DEFAULT,
  parameter int E         = FPHUB_E_DEFAULT,
  parameter int SHW       = $clog2(M),
  parameter int CANCEL_TH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [E+M:0]   in_z,
  input  logic           in_sub,
  input  logic [SHW-1:0] in_shift,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [E+M:0]   out_z,
  output logic [2:0]     out_flags,
  input  logic           clr_status,
  output logic [2:0]     status
`ifdef FPHUB_RESULT_STATS_EN
  ,
  output logic [31:0]    res_count
`endif
);

  localparam int          c_zw        = E + M + 1;
  localparam int          c_pw        = c_zw + 3;
  localparam logic [31:0] c_cancel_th = CANCEL_TH;

  logic [E-1:0]     w_exp;
  logic [M-1:0]     w_frac;
  fphub_res_flags_t w_flags;
  logic [c_pw-1:0]  w_in_data;
  logic [c_pw-1:0]  w_out_data;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_deliver;
  logic [2:0]       r_status;

  assign w_exp  = in_z[E+M-1:M];
  assign w_frac = in_z[M-1:0];

  always_comb begin
    w_flags        = fphub_classify(~|w_exp, &w_exp, ~|w_frac);
    w_flags.cancel = in_sub && (32'(in_shift) >= c_cancel_th);
  end

  assign w_in_data = {in_z, w_flags};

  fphub_skid_buffer #(
    .W (c_pw)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_in_data),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data)
  );

  assign w_accept  = in_valid & w_in_ready;
  assign w_deliver = w_out_valid & out_ready;

  // Clear is applied first so a same-cycle set survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 3'b000;
    end else begin
      r_status <= (clr_status ? 3'b000 : r_status) | (w_accept ? w_flags : 3'b000);
    end
  end

`ifdef FPHUB_RESULT_STATS_EN
  logic [31:0] r_res_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_count <= 32'd0;
    end else if (clr_status) begin
      r_res_count <= w_deliver ? 32'd1 : 32'd0;
    end else if (w_deliver && (r_res_count != 32'hFFFF_FFFF)) begin
      r_res_count <= r_res_count + 32'd1;
    end
  end

  assign res_count = r_res_count;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_z     = w_out_data[c_pw-1:3];
  assign out_flags = w_out_data[2:0];
  assign status    = r_status;

endmodule

`default_nettype wire

// File: tb/tb_fphub_adder_result_stage.sv
// +----------------------------------------------------------------------------+
// | tb_fphub_adder_result_stage                                                |
// | Table-driven and sequence bench with an in-order result scoreboard.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fphub_adder_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic        in_sub;
  logic [4:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [2:0]  out_flags;
  logic        clr_status;
  logic [2:0]  status;
`ifdef FPHUB_RESULT_STATS_EN
  logic [31:0] res_count;
  logic [31:0] exp_cnt;
`endif

  always #5 clk = ~clk;

  fphub_adder_result_stage #(
    .M (23), .E (8), .SHW (5), .CANCEL_TH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_z       (in_z),
    .in_sub     (in_sub),
    .in_shift   (in_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_flags  (out_flags),
    .clr_status (clr_status),
    .status     (status)
`ifdef FPHUB_RESULT_STATS_EN
    ,
    .res_count  (res_count)
`endif
  );

  typedef struct packed {
    logic [31:0] z;
    logic [2:0]  f;
  } exp_t;

  typedef struct packed {
    logic [31:0] z;
    logic        sub;
    logic [4:0]  sh;
    logic [2:0]  ef;
  } vec_t;

  exp_t       sb[$];
  logic [2:0] exp_status;
  int         n_checks;
  int         n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // One clock: called and returning at a falling edge.
  task automatic cycle(input bit v, input logic [31:0] z, input bit sub, input logic [4:0] sh,
                       input logic [2:0] ef, input bit ordy, input bit clr);
    bit   acc;
    bit   del;
    exp_t e;
    chk("status", {29'd0, status}, {29'd0, exp_status});
`ifdef FPHUB_RESULT_STATS_EN
    chk("res_count", res_count, exp_cnt);
`endif
    in_valid   = v;
    in_z       = v ? z : $urandom;
    in_sub     = sub;
    in_shift   = sh;
    out_ready  = ordy;
    clr_status = clr;
    #1;
    acc = v && in_ready;
    del = out_valid && out_ready;
    if (del) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_output: got %08h expected no result", out_z);
      end else begin
        e = sb.pop_front();
        chk("out_z", out_z, e.z);
        chk("out_flags", {29'd0, out_flags}, {29'd0, e.f});
      end
    end
    if (acc) sb.push_back('{z: z, f: ef});
    exp_status = (clr ? 3'b000 : exp_status) | (acc ? ef : 3'b000);
`ifdef FPHUB_RESULT_STATS_EN
    if (clr) exp_cnt = del ? 32'd1 : 32'd0;
    else if (del && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 32'd0, 1'b0, 5'd0, 3'b000, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1'b1);
    chk("drain_left", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_status = 3'b000;
`ifdef FPHUB_RESULT_STATS_EN
    exp_cnt = 32'd0;
`endif
  endtask

  vec_t vecs[11];

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    exp_status = 3'b000;
`ifdef FPHUB_RESULT_STATS_EN
    exp_cnt = 32'd0;
`endif
    in_valid = 1'b0; in_z = 32'd0; in_sub = 1'b0; in_shift = 5'd0;
    out_ready = 1'b0; clr_status = 1'b0;

    vecs[0]  = '{32'h3F80_0000, 1'b0, 5'd0,  3'b000};
    vecs[1]  = '{32'h0000_0000, 1'b0, 5'd0,  3'b001};
    vecs[2]  = '{32'h7FFF_FFFF, 1'b0, 5'd0,  3'b010};
    vecs[3]  = '{32'h8000_0000, 1'b0, 5'd0,  3'b001};
    vecs[4]  = '{32'h7F80_0000, 1'b0, 5'd0,  3'b010};
    vecs[5]  = '{32'h0000_0001, 1'b0, 5'd0,  3'b000};
    vecs[6]  = '{32'h3F80_0000, 1'b1, 5'd10, 3'b100};
    vecs[7]  = '{32'h3F80_0000, 1'b1, 5'd7,  3'b000};
    vecs[8]  = '{32'h3F80_0000, 1'b1, 5'd8,  3'b100};
    vecs[9]  = '{32'h4000_0000, 1'b0, 5'd20, 3'b000};
    vecs[10] = '{32'hFF80_0000, 1'b1, 5'd31, 3'b110};

    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_z", out_z, 32'd0);
    chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
    chk("rst_status", {29'd0, status}, 32'd0);
`ifdef FPHUB_RESULT_STATS_EN
    chk("rst_res_count", res_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single result, one-cycle latency
    cycle(1'b1, 32'h3F80_0000, 1'b0, 5'd0, 3'b000, 1'b1, 1'b0);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_z", out_z, 32'h3F80_0000);
    chk("single_flags", {29'd0, out_flags}, 32'd0);
    drain();

    // Classification table at full throughput
    for (int i = 0; i < 11; i++)
      cycle(1'b1, vecs[i].z, vecs[i].sub, vecs[i].sh, vecs[i].ef, 1'b1, 1'b0);
    drain();

    // Back-pressure: A into OR, B into SR, C held off until SR drains
    cycle(1'b1, 32'h4000_0000, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
    cycle(1'b1, 32'h4040_0000, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("bp_ready_after_b", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_z", out_z, 32'h4000_0000);
    cycle(1'b1, 32'h4080_0000, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("bp_stable_z", out_z, 32'h4000_0000);
    chk("bp_stable_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_sb_depth", sb.size(), 32'd2);
    cycle(1'b1, 32'h4080_0000, 1'b0, 5'd0, 3'b000, 1'b1, 1'b0);
    chk("bp_ready_rise", {31'd0, in_ready}, 32'd1);
    chk("bp_or_is_b", out_z, 32'h4040_0000);
    cycle(1'b1, 32'h4080_0000, 1'b0, 5'd0, 3'b000, 1'b1, 1'b0);
    drain();

    // Random back-pressure over the table entries
    for (int i = 0; i < 40; i++) begin
      int k;
      k = i % 11;
      cycle(1'($urandom_range(0, 1)), vecs[k].z, vecs[k].sub, vecs[k].sh, vecs[k].ef,
            1'($urandom_range(0, 1)), 1'b0);
    end
    drain();

    // Sticky status: set beats a same-cycle clear
    cycle(1'b0, 32'd0, 1'b0, 5'd0, 3'b000, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_0000, 1'b0, 5'd0, 3'b001, 1'b1, 1'b0);
    chk("sticky_zero", {29'd0, status}, 32'd1);
    cycle(1'b1, 32'h7F80_0000, 1'b0, 5'd0, 3'b010, 1'b1, 1'b1);
    chk("sticky_set_wins", {29'd0, status}, 32'd2);
    drain();

    // Asynchronous reset while FULL
    cycle(1'b1, 32'h1111_1111, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 32'h2222_2222, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("full_before_rst", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("rst_discarded", {31'd0, out_valid}, 32'd0);

`ifdef FPHUB_RESULT_STATS_EN
    for (int i = 0; i < 5; i++)
      cycle(1'b1, vecs[i].z, vecs[i].sub, vecs[i].sh, vecs[i].ef, 1'b1, 1'b0);
    drain();
    chk("count_five", res_count, 32'd5);
    force dut.r_res_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_res_count;
    exp_cnt = 32'hFFFF_FFFF;
    cycle(1'b1, 32'h3F80_0000, 1'b0, 5'd0, 3'b000, 1'b1, 1'b0);
    drain();
    chk("count_saturated", res_count, 32'hFFFF_FFFF);
`endif

    idle(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/fphub_adder_result_stage.md
# fphub_adder_result_stage

Registered output stage placed directly downstream of the combinational FPHUB adder. It captures the adder's packed result `Z` and its subtraction/LZA side information behind a valid/ready handshake, using a 2-entry skid buffer. Each result is classified as zero, saturated or massively cancelled, and the classification is accumulated in sticky status flags. This gives the adder a registered, back-pressurable boundary toward the consuming datapath.

## Interface
- `M`, 23: mantissa field width of the HUB word.
- `E`, 8: exponent field width.
- `SHW`, `$clog2(M)`: width of the LZA shift count.
- `CANCEL_TH`, 8: LZA shift threshold at or above which a subtraction counts as massive cancellation.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  adder result present.
- `in_ready`  out  1  stage can accept a result.
- `in_z`  in  E+M+1  packed adder result: {sign, exponent, fraction}.
- `in_sub`  in  1  adder performed an effective subtraction.
- `in_shift`  in  SHW  LZA normalization shift used by the adder.
- `out_valid`  out  1  registered result available.
- `out_ready`  in  1  consumer accepts.
- `out_z`  out  E+M+1  registered result.
- `out_flags`  out  3  {cancel, sat, zero} for `out_z`.
- `clr_status`  in  1  synchronous clear of sticky status (and counter).
- `status`  out  3  sticky {cancel, sat, zero}.
- `res_count`  out  32  results delivered; present only with the macro in Configuration.

## Operation
- Classification is computed on `in_z` at input acceptance and stored with the entry:
  - zero = `in_z[E+M-1:M]` == 0 and `in_z[M-1:0]` == 0.
  - sat = exponent field all ones.
  - cancel = `in_sub` && `in_shift` >= `CANCEL_TH`.
- Storage is an output register (OR) plus a skid register (SR).
- Accept = `in_valid && in_ready`; deliver = `out_valid && out_ready`.
- Effective state is one of EMPTY (OR and SR empty), ONE (OR full, SR empty) or FULL (both full).
  - EMPTY: accept → ONE (load OR).
  - ONE:
    - accept && deliver → ONE (reload OR).
    - accept && !deliver → FULL (load SR).
    - deliver && !accept → EMPTY.
    - neither → ONE (hold).
  - FULL: deliver → ONE (SR moves into OR); otherwise hold.
- `in_ready` = SR empty; it is a registered signal with no combinational path from `out_ready`.
- `out_valid` = OR full. `out_z` and `out_flags` are stable while `out_valid && !out_ready`.
- Results are delivered in acceptance order. No result is dropped or duplicated.
- Status: each bit is set on acceptance of an entry whose corresponding flag is 1. `clr_status` clears all bits. If a set and a clear occur in the same cycle, the set wins.
- Reset asserted mid-operation discards both entries immediately.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 result/cycle while `out_ready` = 1.
- `in_ready` falls the cycle after SR fills. It rises the cycle after the deliver that drains SR.
- Reset values:
  - `out_valid` = 0, `in_ready` = 1.
  - `out_z` = 0, `out_flags` = 0.
  - `status` = 0, `res_count` = 0.
- `in_*` are sampled only on accept. `in_z` may change freely otherwise.

## Configuration
- Macro: `FPHUB_RESULT_STATS_EN`.
- Defined:
  - `res_count` increments on every deliver and saturates at 32'hFFFF_FFFF.
  - `clr_status` zeroes it. If a clear and a deliver occur in the same cycle, the result is 1.
- Undefined: the `res_count` port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `fphub_pkg`:
  - `typedef struct packed {logic cancel, sat, zero;} fphub_res_flags_t`.
  - Default `M`/`E` constants.
  - A classification function for the zero/sat flags.
- One sub-module: `fphub_skid_buffer`, a generic 2-entry valid/ready buffer parameterized by payload width. It carries `{in_z, flags}`.
- Top level contains classification, sticky status and the optional counter.

## Test plan
- Single result: accept `in_z`=32'h3F80_0000 with `out_ready`=1 → next cycle `out_valid`=1, `out_z`=32'h3F80_0000, `out_flags`=3'b000.
- Back-pressure: hold `out_ready`=0 and present results A=32'h4000_0000 then B=32'h4040_0000:
  - `in_ready` drops after B is accepted.
  - Raising `out_ready` delivers A then B in order, with no C accepted until SR drains.
- Classification:
  - `in_z`=32'h0000_0000 → flags 3'b001.
  - `in_z`=32'h7FFF_FFFF → flags 3'b010.
  - `in_sub`=1 with `in_shift`=10 → cancel=1.
  - `in_sub`=1 with `in_shift`=7 → cancel=0.
- Sticky: zero result then `clr_status` together with accept of a sat result → `status`=3'b010.
- Reset mid-FULL: assert `rst_n`=0 asynchronously → immediately `out_valid`=0 and `in_ready`=1. The held entries never appear.
- Macro on: stream 5 results with `out_ready`=1 → `res_count`=5. Preload 32'hFFFF_FFFF and deliver once → value unchanged.
